// File: rtl/instr_cache_pkg.sv
// Shared definitions for the instruction cache: FSM encoding, address
// geometry constants and the block word-select helper.
package icache_defs;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MEM_RD = 2'd1,
      UPDATE = 2'd2
   } state_e;

   localparam int ADDR_BITS    = 10;
   localparam int OFFSET_BITS  = 4;
   localparam int WORD_BITS    = 32;
   localparam int BLOCK_BITS   = 128;
   localparam int BLKADDR_BITS = ADDR_BITS - OFFSET_BITS;

   // Pick word 0..3 out of a 128-bit block (word k sits at bits [32k+31:32k]).
   function automatic logic [WORD_BITS-1:0] select_word(
      input logic [BLOCK_BITS-1:0] blk,
      input logic [1:0]            off
   );
      logic [WORD_BITS-1:0] w;
      case (off)
         2'd0:    w = blk[31:0];
         2'd1:    w = blk[63:32];
         2'd2:    w = blk[95:64];
         2'd3:    w = blk[127:96];
         default: w = 32'd0;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/icache_ctrl.sv
// Miss/refill sequencer: IDLE -> MEM_RD -> UPDATE, owning the registered
// memory request and the one-cycle fill strobe for the block arrays.
module icache_ctrl
   import icache_defs::*;
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    miss,
   input  logic [BLKADDR_BITS-1:0] pc_block,
   input  logic                    mem_busywait,
   output logic                    idle,
   output logic                    fill_en,
   output logic                    mem_read,
   output logic [BLKADDR_BITS-1:0] mem_address
);

   state_e                  state_q, state_d;
   logic                    mem_read_q, mem_read_d;
   logic [BLKADDR_BITS-1:0] mem_address_q, mem_address_d;

   // Next-state and request logic; the fill strobe is suppressed under reset
   // so an aborted refill never writes a block.
   always_comb begin
      state_d       = state_q;
      mem_read_d    = mem_read_q;
      mem_address_d = mem_address_q;
      fill_en       = 1'b0;
      case (state_q)
         IDLE: begin
            if (miss) begin
               state_d       = MEM_RD;
               mem_read_d    = 1'b1;
               mem_address_d = pc_block;
            end else begin
               state_d = IDLE;
            end
         end
         MEM_RD: begin
            if (!mem_busywait) begin
               fill_en    = !reset;
               state_d    = UPDATE;
               mem_read_d = 1'b0;
            end else begin
               state_d = MEM_RD;
            end
         end
         UPDATE: begin
            state_d = IDLE;
         end
         default: begin
            state_d    = IDLE;
            mem_read_d = 1'b0;
         end
      endcase
   end

   // State and memory-request registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         mem_read_q    <= 1'b0;
         mem_address_q <= {BLKADDR_BITS{1'b0}};
      end else begin
         state_q       <= state_d;
         mem_read_q    <= mem_read_d;
         mem_address_q <= mem_address_d;
      end
   end

   assign idle        = (state_q == IDLE);
   assign mem_read    = mem_read_q;
   assign mem_address = mem_address_q;

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache: valid/tag/data arrays, hit
// compare and word mux; refills are sequenced by icache_ctrl.
module instr_cache
   import icache_defs::*;
#(
   parameter int INDEX_BITS = 3
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic [31:0]             PC,
   output logic [31:0]             INSTRUCTION,
   output logic                    BUSYWAIT,
   output logic                    MEM_READ,
   output logic [5:0]              MEM_ADDRESS,
   input  logic [127:0]            MEM_READDATA,
   input  logic                    MEM_BUSYWAIT
);

   localparam int NUM_BLOCKS = 1 << INDEX_BITS;
   localparam int TAG_BITS   = BLKADDR_BITS - INDEX_BITS;

   logic [NUM_BLOCKS-1:0] valid_q, valid_d;
   logic [TAG_BITS-1:0]   tag_q  [NUM_BLOCKS];
   logic [TAG_BITS-1:0]   tag_d  [NUM_BLOCKS];
   logic [BLOCK_BITS-1:0] data_q [NUM_BLOCKS];
   logic [BLOCK_BITS-1:0] data_d [NUM_BLOCKS];

   logic [BLKADDR_BITS-1:0] pc_block_s;
   logic [INDEX_BITS-1:0]   index_s, fill_index_s;
   logic [TAG_BITS-1:0]     tag_s, fill_tag_s;
   logic [1:0]              offset_s;
   logic                    lookup_hit_s, hit_s, idle_s, fill_en_s;
   logic                    unused_pc_s;

   assign pc_block_s  = PC[ADDR_BITS-1:OFFSET_BITS];
   assign index_s     = pc_block_s[INDEX_BITS-1:0];
   assign tag_s       = pc_block_s[BLKADDR_BITS-1:INDEX_BITS];
   assign offset_s    = PC[OFFSET_BITS-1:2];
   assign unused_pc_s = ^{PC[31:ADDR_BITS], PC[1:0]};

   // Refill target comes from the registered request, never the live PC.
   assign fill_index_s = MEM_ADDRESS[INDEX_BITS-1:0];
   assign fill_tag_s   = MEM_ADDRESS[BLKADDR_BITS-1:INDEX_BITS];

   assign lookup_hit_s = valid_q[index_s] && (tag_q[index_s] == tag_s);
   assign hit_s        = !RESET && idle_s && lookup_hit_s;
   assign BUSYWAIT     = !hit_s && !RESET;
   assign INSTRUCTION  = hit_s ? select_word(data_q[index_s], offset_s) : 32'd0;

   icache_ctrl u_ctrl (
      .clk          (CLK),
      .reset        (RESET),
      .miss         (!lookup_hit_s),
      .pc_block     (pc_block_s),
      .mem_busywait (MEM_BUSYWAIT),
      .idle         (idle_s),
      .fill_en      (fill_en_s),
      .mem_read     (MEM_READ),
      .mem_address  (MEM_ADDRESS)
   );

   // Block update: a fill overwrites the resident block unconditionally.
   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      data_d  = data_q;
      if (fill_en_s) begin
         valid_d[fill_index_s] = 1'b1;
         tag_d[fill_index_s]   = fill_tag_s;
         data_d[fill_index_s]  = MEM_READDATA;
      end else begin
         valid_d = valid_q;
      end
   end

   // Valid bits are cleared by reset; tag and data need no reset.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         valid_q <= {NUM_BLOCKS{1'b0}};
      end else begin
         valid_q <= valid_d;
      end
   end

   // Tag and data storage.
   always_ff @(posedge CLK) begin
      tag_q  <= tag_d;
      data_q <= data_d;
   end

endmodule
